// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: segment indices, active-high glyph patterns,
// the invalid-digit code and the capture FSM states. Also used by the display driver.
package seven_seg_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] PAT_0 = 7'h3F;
    localparam logic [6:0] PAT_1 = 7'h06;
    localparam logic [6:0] PAT_2 = 7'h5B;
    localparam logic [6:0] PAT_3 = 7'h4F;
    localparam logic [6:0] PAT_4 = 7'h66;
    localparam logic [6:0] PAT_5 = 7'h6D;
    localparam logic [6:0] PAT_6 = 7'h7D;
    localparam logic [6:0] PAT_7 = 7'h07;
    localparam logic [6:0] PAT_8 = 7'h7F;
    localparam logic [6:0] PAT_9 = 7'h6F;
    localparam logic [6:0] PAT_A = 7'h77;
    localparam logic [6:0] PAT_B = 7'h7C;
    localparam logic [6:0] PAT_C = 7'h39;
    localparam logic [6:0] PAT_D = 7'h5E;
    localparam logic [6:0] PAT_E = 7'h79;
    localparam logic [6:0] PAT_F = 7'h71;

    localparam logic [3:0] DIGIT_INVALID = 4'hF;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_CAPTURE,
        ST_HOLD
    } capture_state_t;

endpackage

// File: rtl/seven_seg_capture_if.sv
// Multiplexed 7-segment display bus: the driver is the master, monitors are slaves.
interface seven_seg_capture_if;

    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    modport master (output seg, dp, an);
    modport slave  (input  seg, dp, an);

endinterface

// File: rtl/seven_seg_decode.sv
// Combinational active-high segment pattern to digit code decoder.
// Define SEVEN_SEG_CAPTURE_HEX_EN to accept the hex glyphs A-F as valid digits.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       valid
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        code  = DIGIT_INVALID;
        valid = 1'b0;
        case (pattern)
            PAT_0: {code, valid} = {4'h0, 1'b1};
            PAT_1: {code, valid} = {4'h1, 1'b1};
            PAT_2: {code, valid} = {4'h2, 1'b1};
            PAT_3: {code, valid} = {4'h3, 1'b1};
            PAT_4: {code, valid} = {4'h4, 1'b1};
            PAT_5: {code, valid} = {4'h5, 1'b1};
            PAT_6: {code, valid} = {4'h6, 1'b1};
            PAT_7: {code, valid} = {4'h7, 1'b1};
            PAT_8: {code, valid} = {4'h8, 1'b1};
            PAT_9: {code, valid} = {4'h9, 1'b1};
`ifdef SEVEN_SEG_CAPTURE_HEX_EN
            PAT_A: {code, valid} = {4'hA, 1'b1};
            PAT_B: {code, valid} = {4'hB, 1'b1};
            PAT_C: {code, valid} = {4'hC, 1'b1};
            PAT_D: {code, valid} = {4'hD, 1'b1};
            PAT_E: {code, valid} = {4'hE, 1'b1};
            PAT_F: {code, valid} = {4'hF, 1'b1};
`else
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive-side monitor for the multiplexed 7-segment bus: settles, decodes and
// assembles four-digit frames. Hex glyph decoding is enabled by SEVEN_SEG_CAPTURE_HEX_EN.
module seven_seg_capture #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int STALE_CYCLES   = 65536,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    seven_seg_capture_if.slave  bus,
    output logic [15:0]         bcd,
    output logic [3:0]          dp_out,
    output logic                frame_valid,
    output logic                frame_err,
    output logic                stale
);
    import seven_seg_pkg::*;

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int STALE_W  = (STALE_CYCLES > 2) ? $clog2(STALE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [STALE_W-1:0]  STALE_MAX  = STALE_W'(STALE_CYCLES - 1);

    logic [11:0]         sync1, sync2;
    logic [3:0]          cur_an;
    logic                cur_dp;
    logic [6:0]          cur_seg;
    logic [11:0]         cur, prev;
    logic                an_onehot;
    logic                changed;
    logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
    capture_state_t      state;
    logic                capture_now;
    logic [3:0]          dec_code;
    logic                dec_valid;
    logic [15:0]         shadow_bcd;
    logic [3:0]          shadow_dp, shadow_err;
    logic [3:0]          mask;
    logic [STALE_W-1:0]  stale_cnt;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so sync2 takes sync1's old value and the two flops stay distinct.
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {bus.an, bus.dp, bus.seg};
            sync2 <= sync1;
        end
    end

    assign cur_an    = AN_ACTIVE_LOW  ? ~sync2[11:8] : sync2[11:8];
    assign cur_dp    = SEG_ACTIVE_LOW ? ~sync2[7]    : sync2[7];
    assign cur_seg   = SEG_ACTIVE_LOW ? ~sync2[6:0]  : sync2[6:0];
    assign cur       = {cur_an, cur_dp, cur_seg};
    assign an_onehot = $onehot(cur_an);
    assign changed   = (cur != prev);

    always_comb begin
        settle_nxt = settle_cnt;
        if (!an_onehot || changed) begin
            settle_nxt = '0;
        end else if (settle_cnt != SETTLE_MAX) begin
            settle_nxt = settle_cnt + SETTLE_W'(1);
        end
    end

    // The count only reaches SETTLE_MAX with a one-hot selection, and WAIT is only
    // re-entered after it drops, so each stable interval yields one capture.
    assign capture_now = (state == ST_WAIT) && (settle_nxt == SETTLE_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev       <= '0;
            settle_cnt <= '0;
        end else begin
            prev       <= cur;
            settle_cnt <= settle_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_WAIT;
        end else begin
            case (state)
                ST_WAIT:    if (capture_now) state <= ST_CAPTURE;
                ST_CAPTURE: state <= ST_HOLD;
                ST_HOLD:    if (settle_nxt != SETTLE_MAX) state <= ST_WAIT;
                default:    state <= ST_WAIT;
            endcase
        end
    end

    seven_seg_decode u_decode (
        .pattern (cur_seg),
        .code    (dec_code),
        .valid   (dec_valid)
    );

    // NOTE: shadow storage has no reset; the mask alone says which entries are live.
    always_ff @(posedge clk) begin
        if (capture_now) begin
            for (int k = 0; k < 4; k++) begin
                if (cur_an[k]) begin
                    shadow_bcd[4*k +: 4] <= dec_code;
                    shadow_dp[k]         <= cur_dp;
                    shadow_err[k]        <= !dec_valid;
                end
            end
        end
    end

    // A capture landing on the commit edge seeds the next frame's mask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask        <= '0;
            bcd         <= '0;
            dp_out      <= '0;
            frame_err   <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (&mask) begin
                bcd         <= shadow_bcd;
                dp_out      <= shadow_dp;
                frame_err   <= |shadow_err;
                frame_valid <= 1'b1;
                mask        <= capture_now ? cur_an : 4'b0000;
            end else if (capture_now) begin
                mask <= mask | cur_an;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stale_cnt <= STALE_MAX;
            stale     <= 1'b1;
        end else begin
            stale <= (stale_cnt == STALE_MAX);
            if ((&mask) || frame_valid) begin
                stale_cnt <= '0;
            end else if (stale_cnt != STALE_MAX) begin
                stale_cnt <= stale_cnt + STALE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: scans digit frames over the display bus
// and checks committed frames, glitch rejection, invalid selects, reset and stale.
module tb_seven_seg_capture;
    import seven_seg_pkg::*;

    localparam int SETTLE = 4;
    localparam int STALE  = 256;
    localparam int HOLD   = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bcd;
    logic [3:0]  dp_out;
    logic        frame_valid, frame_err, stale;

    int   tests = 0;
    int   fails = 0;
    int   fv_count = 0;
    int   back_to_back = 0;
    logic prev_fv = 1'b0;
    logic stale_at_fv = 1'b0;
    logic stale_after_fv = 1'b0;
    int   base;
    logic [15:0] exp_hex_bcd;
    logic        exp_hex_err;

    seven_seg_capture_if bus_if ();

    seven_seg_capture #(
        .SETTLE_CYCLES  (SETTLE),
        .STALE_CYCLES   (STALE),
        .SEG_ACTIVE_LOW (1'b0),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if),
        .bcd         (bcd),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prev_fv) stale_after_fv = stale;
        if (frame_valid) begin
            fv_count = fv_count + 1;
            stale_at_fv = stale;
            if (prev_fv) back_to_back = back_to_back + 1;
        end
        prev_fv = frame_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests = tests + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_pins(input logic [3:0] an_pins, input logic [6:0] seg, input logic dp);
        bus_if.an  = an_pins;
        bus_if.seg = seg;
        bus_if.dp  = dp;
    endtask

    task automatic show_digit(input int k, input logic [6:0] pat, input logic dp, input int cycles);
        logic [3:0] sel;
        sel = 4'b0001 << k;
        set_pins(~sel, pat, dp);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic go_idle(input int cycles);
        set_pins(4'hF, 7'h00, 1'b0);
        repeat (cycles) @(negedge clk);
        #1;
    endtask

    task automatic scan(input logic [6:0] p3, input logic [6:0] p2, input logic [6:0] p1,
                        input logic [6:0] p0, input logic [3:0] dps);
        show_digit(3, p3, dps[3], HOLD);
        show_digit(2, p2, dps[2], HOLD);
        show_digit(1, p1, dps[1], HOLD);
        show_digit(0, p0, dps[0], HOLD);
        go_idle(6);
    endtask

    initial begin
        rst_n = 1'b0;
        set_pins(4'hF, 7'h00, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_bcd", bcd, 16'h0000);
        check("rst_dp_out", dp_out, 4'h0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_frame_valid", frame_valid, 1'b0);
        check("rst_stale", stale, 1'b1);
        rst_n = 1'b1;

        go_idle(STALE);
        check("idle_no_frame", fv_count, 0);
        check("idle_stale", stale, 1'b1);
        check("idle_bcd", bcd, 16'h0000);

        // 1,2,3,4 with the decimal point on digit 2 only
        base = fv_count;
        scan(PAT_1, PAT_2, PAT_3, PAT_4, 4'b0100);
        check("f1234_count", fv_count - base, 1);
        check("f1234_bcd", bcd, 16'h1234);
        check("f1234_dp", dp_out, 4'b0100);
        check("f1234_err", frame_err, 1'b0);
        check("f1234_stale_at_commit", stale_at_fv, 1'b1);
        check("f1234_stale_after", stale_after_fv, 1'b0);

        // one-cycle 8 glitch inside the digit-2 slot
        base = fv_count;
        show_digit(3, PAT_1, 1'b0, HOLD);
        show_digit(2, PAT_2, 1'b0, HOLD);
        show_digit(2, PAT_8, 1'b0, 1);
        show_digit(2, PAT_2, 1'b0, HOLD);
        show_digit(1, PAT_3, 1'b0, HOLD);
        show_digit(0, PAT_4, 1'b0, HOLD);
        go_idle(6);
        check("glitch_count", fv_count - base, 1);
        check("glitch_bcd", bcd, 16'h1234);
        check("glitch_dp", dp_out, 4'b0000);

`ifdef SEVEN_SEG_CAPTURE_HEX_EN
        exp_hex_bcd = 16'h12A4;
        exp_hex_err = 1'b0;
`else
        exp_hex_bcd = 16'h12F4;
        exp_hex_err = 1'b1;
`endif
        base = fv_count;
        scan(PAT_1, PAT_2, PAT_A, PAT_4, 4'b0000);
        check("hexa_count", fv_count - base, 1);
        check("hexa_bcd", bcd, exp_hex_bcd);
        check("hexa_err", frame_err, exp_hex_err);

        // zero-hot and multi-hot selects in the middle of a frame
        base = fv_count;
        show_digit(3, PAT_5, 1'b0, HOLD);
        show_digit(2, PAT_6, 1'b0, HOLD);
        set_pins(4'b1111, PAT_8, 1'b1);
        repeat (20) @(negedge clk);
        set_pins(4'b1100, PAT_8, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        check("badsel_no_commit", fv_count - base, 0);
        show_digit(1, PAT_7, 1'b0, HOLD);
        show_digit(0, PAT_8, 1'b0, HOLD);
        go_idle(6);
        check("badsel_count", fv_count - base, 1);
        check("badsel_bcd", bcd, 16'h5678);
        check("badsel_dp", dp_out, 4'b0000);

        // reset after three of four digits captured
        show_digit(3, PAT_1, 1'b1, HOLD);
        show_digit(2, PAT_2, 1'b1, HOLD);
        show_digit(1, PAT_3, 1'b1, HOLD);
        @(negedge clk);
        rst_n = 1'b0;
        set_pins(4'hF, 7'h00, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("midrst_bcd", bcd, 16'h0000);
        check("midrst_dp_out", dp_out, 4'h0);
        check("midrst_frame_err", frame_err, 1'b0);
        check("midrst_stale", stale, 1'b1);
        rst_n = 1'b1;

        // digit 0 first: stale partial shadows would complete a frame here
        base = fv_count;
        show_digit(0, PAT_7, 1'b0, HOLD);
        show_digit(3, PAT_5, 1'b0, HOLD);
        show_digit(2, PAT_9, 1'b0, HOLD);
        show_digit(1, PAT_0, 1'b0, HOLD);
        go_idle(6);
        check("f5907_count", fv_count - base, 1);
        check("f5907_bcd", bcd, 16'h5907);
        check("f5907_err", frame_err, 1'b0);

        go_idle(190);
        check("stale_low_before_limit", stale, 1'b0);
        go_idle(100);
        check("stale_high_after_limit", stale, 1'b1);

        check("fv_back_to_back", back_to_back, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
